sam_vram_fetch: RTL and testbench

- Upstream of the video controller. Turns its toggle-style VRAM fetch request into two sequential 16-bit reads on a shared single-port memory handshake.
- Arbitrates that memory against CPU byte accesses; video always has priority.
- Returns both words to the video controller atomically, so vram_dout1/vram_dout2 never show a mixed pair.

---
 rtl/sam_vram_pkg.sv | 22 ++
 rtl/sam_toggle_detect.sv | 18 +
 rtl/sam_vram_fetch.sv | 189 ++++++++++++++++++
 tb/tb_sam_vram_fetch.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sam_vram_pkg.sv
// sam_vram_pkg: shared types and helpers for the VRAM fetch arbiter.
// Holds the FSM encoding, default widths and byte-enable mapping.
package sam_vram_pkg;

  localparam int SAM_AW = 19;
  localparam int SAM_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_V1,
    ST_V2,
    ST_CPU
  } fetch_st_t;

  function automatic logic [1:0] be_map(
    input logic we,
    input logic a0
  );
    return we ? {a0, ~a0} : 2'b11;
  endfunction

endpackage

// File: rtl/sam_toggle_detect.sv
// sam_toggle_detect: flags any level change of a toggle request line.
// Reset re-arms the history to the current level, so no edge leaks out.
module sam_toggle_detect (
  input  logic CLK_VIDEO,
  input  logic reset,
  input  logic i_lvl,
  output logic o_edge
);

  logic r_prev;

  always_ff @(posedge CLK_VIDEO) begin
    r_prev <= i_lvl;
  end

  assign o_edge = ~reset & (i_lvl ^ r_prev);

endmodule

// File: rtl/sam_vram_fetch.sv
// sam_vram_fetch: video word-pair fetch and CPU byte access on one port.
// Optional saturating overrun counter: define SAM_VRAM_OVERRUN_CNT_EN.
module sam_vram_fetch
  import sam_vram_pkg::*;
#(
  parameter int AW = SAM_AW,
  parameter int DW = SAM_DW
) (
  input  logic          CLK_VIDEO,
  input  logic          reset,
  input  logic          vram_rd,
  input  logic [AW-1:0] vram_addr1,
  input  logic [AW-1:0] vram_addr2,
  output logic [DW-1:0] vram_dout1,
  output logic [DW-1:0] vram_dout2,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [1:0]    mem_be,
  output logic [AW-2:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ack,
  output logic          overrun
`ifdef SAM_VRAM_OVERRUN_CNT_EN
  ,
  input  logic          cpu_clr_cnt,
  output logic [7:0]    overrun_cnt
`endif
);

  logic          w_vedge;
  logic          w_ack;
  logic          w_vbusy;
  logic          w_unused;

  fetch_st_t     r_st;
  logic          r_vpend;
  logic          r_cpend;
  logic          r_busy;
  logic          r_cwe;
  logic [AW-2:0] r_a1;
  logic [AW-2:0] r_a2;
  logic [AW-2:0] r_ca2;
  logic [AW-1:0] r_caddr;
  logic [7:0]    r_cdin;
  logic [DW-1:0] r_w1;

  sam_toggle_detect u_tog (
    .CLK_VIDEO (CLK_VIDEO),
    .reset     (reset),
    .i_lvl     (vram_rd),
    .o_edge    (w_vedge)
  );

  // mem_req is registered, so an ack in the request cycle is not ours.
  assign w_ack    = mem_ack & r_busy & ~mem_req;
  assign w_vbusy  = (r_st == ST_V1) | (r_st == ST_V2);
  assign w_unused = &{1'b0, vram_addr1[0], vram_addr2[0]};

  always_ff @(posedge CLK_VIDEO) begin
    if (reset) begin
      r_st       <= ST_IDLE;
      r_vpend    <= 1'b0;
      r_cpend    <= 1'b0;
      r_busy     <= 1'b0;
      r_cwe      <= 1'b0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_ca2      <= '0;
      r_caddr    <= '0;
      r_cdin     <= '0;
      r_w1       <= '0;
      vram_dout1 <= '0;
      vram_dout2 <= '0;
      cpu_dout   <= '0;
      cpu_done   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      overrun    <= 1'b0;
    end else begin
      mem_req  <= 1'b0;
      cpu_done <= 1'b0;
      if (w_ack)
        r_busy <= 1'b0;
      if (w_vedge && w_vbusy)
        overrun <= 1'b1;
      if (cpu_req && !r_cpend) begin
        r_cpend <= 1'b1;
        r_cwe   <= cpu_we;
        r_caddr <= cpu_addr;
        r_cdin  <= cpu_din;
      end

      unique case (r_st)
        ST_IDLE: begin
          if (r_vpend) begin
            r_st     <= ST_V1;
            r_vpend  <= 1'b0;
            r_ca2    <= r_a2;
            r_busy   <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_be   <= be_map(1'b0, 1'b0);
            mem_addr <= r_a1;
          end else if (r_cpend) begin
            r_st     <= ST_CPU;
            r_busy   <= 1'b1;
            mem_req  <= 1'b1;
            mem_we   <= r_cwe;
            mem_be   <= be_map(r_cwe, r_caddr[0]);
            mem_addr <= r_caddr[AW-1:1];
            mem_din  <= {(DW/8){r_cdin}};
          end
        end
        ST_V1: begin
          if (w_ack) begin
            r_st     <= ST_V2;
            r_w1     <= mem_dout;
            r_busy   <= 1'b1;
            mem_req  <= 1'b1;
            mem_addr <= r_ca2;
          end
        end
        ST_V2: begin
          if (w_ack) begin
            vram_dout1 <= r_w1;
            vram_dout2 <= mem_dout;
            if (r_vpend) begin
              r_st     <= ST_V1;
              r_vpend  <= 1'b0;
              r_ca2    <= r_a2;
              r_busy   <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_be   <= be_map(1'b0, 1'b0);
              mem_addr <= r_a1;
            end else if (r_cpend) begin
              r_st     <= ST_CPU;
              r_busy   <= 1'b1;
              mem_req  <= 1'b1;
              mem_we   <= r_cwe;
              mem_be   <= be_map(r_cwe, r_caddr[0]);
              mem_addr <= r_caddr[AW-1:1];
              mem_din  <= {(DW/8){r_cdin}};
            end else begin
              r_st <= ST_IDLE;
            end
          end
        end
        ST_CPU: begin
          if (w_ack) begin
            r_st     <= ST_IDLE;
            r_cpend  <= 1'b0;
            cpu_done <= 1'b1;
            if (!r_cwe)
              cpu_dout <= r_caddr[0] ? mem_dout[DW-1 -: 8]
                                     : mem_dout[7:0];
          end
        end
      endcase

      // Newest edge wins over the clear of an issued request.
      if (w_vedge) begin
        r_vpend <= 1'b1;
        r_a1    <= vram_addr1[AW-1:1];
        r_a2    <= vram_addr2[AW-1:1];
      end
    end
  end

`ifdef SAM_VRAM_OVERRUN_CNT_EN
  always_ff @(posedge CLK_VIDEO) begin
    if (reset || cpu_clr_cnt)
      overrun_cnt <= '0;
    else if (w_vedge && w_vbusy && overrun_cnt != 8'hFF)
      overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sam_vram_fetch.sv
// tb_sam_vram_fetch: randomized self-checking bench for sam_vram_fetch.
// Memory responder plus pair/byte scoreboards derived from address rules.
module tb_sam_vram_fetch;

  localparam int AW = 19;
  localparam int DW = 16;

  logic          CLK_VIDEO = 1'b0;
  logic          reset = 1'b1;
  logic          vram_rd = 1'b0;
  logic [AW-1:0] vram_addr1 = '0;
  logic [AW-1:0] vram_addr2 = '0;
  logic [DW-1:0] vram_dout1;
  logic [DW-1:0] vram_dout2;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [7:0]    cpu_din = '0;
  logic [7:0]    cpu_dout;
  logic          cpu_done;
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [AW-2:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic          mem_ack = 1'b0;
  logic          overrun;
`ifdef SAM_VRAM_OVERRUN_CNT_EN
  logic          cpu_clr_cnt = 1'b0;
  logic [7:0]    overrun_cnt;
`endif

  always #5 CLK_VIDEO = ~CLK_VIDEO;

  sam_vram_fetch #(.AW(AW), .DW(DW)) dut (
    .CLK_VIDEO  (CLK_VIDEO),
    .reset      (reset),
    .vram_rd    (vram_rd),
    .vram_addr1 (vram_addr1),
    .vram_addr2 (vram_addr2),
    .vram_dout1 (vram_dout1),
    .vram_dout2 (vram_dout2),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .cpu_done   (cpu_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_ack    (mem_ack),
    .overrun    (overrun)
`ifdef SAM_VRAM_OVERRUN_CNT_EN
    ,
    .cpu_clr_cnt(cpu_clr_cnt),
    .overrun_cnt(overrun_cnt)
`endif
  );

  typedef struct { int w1; int w2; } pair_t;
  typedef struct { logic we; logic [AW-1:0] addr; } cpu_t;
  typedef struct {
    logic [AW-2:0] addr;
    logic          we;
    logic [1:0]    be;
    logic [15:0]   din;
  } log_t;
  typedef struct { int due; logic [15:0] data; } rsp_t;

  logic [15:0] mem [int];
  pair_t vq[$];
  cpu_t  cq[$];
  log_t  lg[$];
  rsp_t  rq[$];
  int    cyc = 0;
  int    lat = 2;
  bit    lat_rand = 1'b0;
  int    n_vupd = 0;
  int    n_done = 0;
  int    n_tests = 0;
  int    n_fail = 0;
  logic [15:0] pv1 = '0;
  logic [15:0] pv2 = '0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rd(int w);
    if (mem.exists(w))
      return mem[w];
    return 16'((w * 40503) ^ (w >> 5) ^ 32'h5A5A);
  endfunction

  function automatic logic [7:0] bsel(logic [15:0] d, logic hi);
    return hi ? d[15:8] : d[7:0];
  endfunction

  function automatic logic [AW-1:0] vaddr();
    return AW'($urandom_range(32'h20000, 32'h7FFFF));
  endfunction

  function automatic logic [AW-1:0] raddr();
    return AW'($urandom_range(32'h100, 32'hFFF));
  endfunction

  // Memory responder and output scoreboards, sampled 1ns after the edge.
  initial forever begin
    @(posedge CLK_VIDEO);
    #1;
    cyc++;
    mem_ack = 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_ack  = 1'b1;
      mem_dout = rq[0].data;
      void'(rq.pop_front());
    end
    if (mem_req) begin
      automatic int w = int'(mem_addr);
      automatic logic [15:0] d = rd(w);
      automatic int l = lat_rand ? int'($urandom_range(1, 4)) : lat;
      lg.push_back('{mem_addr, mem_we, mem_be, mem_din});
      if (mem_we) begin
        if (mem_be[1]) d[15:8] = mem_din[15:8];
        if (mem_be[0]) d[7:0]  = mem_din[7:0];
        mem[w] = d;
      end
      rq.push_back('{cyc + l, d});
    end
    if (reset) begin
      pv1 = vram_dout1;
      pv2 = vram_dout2;
    end else if (vram_dout1 !== pv1 || vram_dout2 !== pv2) begin
      automatic int hit = -1;
      foreach (vq[i])
        if (hit < 0 && rd(vq[i].w1) == vram_dout1 &&
            rd(vq[i].w2) == vram_dout2)
          hit = i;
      chk("vid_pair", 32'(hit >= 0), 32'd1);
      for (int k = 0; k <= hit; k++)
        void'(vq.pop_front());
      n_vupd++;
      pv1 = vram_dout1;
      pv2 = vram_dout2;
    end
    if (!reset && cpu_done) begin
      n_done++;
      chk("cpu_done_extra", 32'(cq.size() > 0), 32'd1);
      if (cq.size() > 0) begin
        automatic cpu_t e = cq.pop_front();
        if (!e.we)
          chk("cpu_dout", 32'(cpu_dout),
              32'(bsel(rd(int'(e.addr >> 1)), e.addr[0])));
      end
    end
  end

  task automatic tick();
    @(posedge CLK_VIDEO);
    #2;
  endtask

  task automatic vid(logic [AW-1:0] a1, logic [AW-1:0] a2);
    vram_addr1 = a1;
    vram_addr2 = a2;
    vram_rd    = ~vram_rd;
    vq.push_back('{int'(a1 >> 1), int'(a2 >> 1)});
  endtask

  task automatic cpu(logic we, logic [AW-1:0] a, logic [7:0] d);
    cpu_req  = 1'b1;
    cpu_we   = we;
    cpu_addr = a;
    cpu_din  = d;
    cq.push_back('{we, a});
    tick();
    cpu_req = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int n = 0;
    while ((vq.size() + cq.size() + rq.size()) != 0 && n < 500) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 500), 32'd1);
    repeat (3) tick();
  endtask

  task automatic wait_log(string tag, int k);
    int n = 0;
    while (lg.size() < k && n < 100) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 100), 32'd1);
  endtask

  task automatic chk_rst(string tag);
    chk({tag, "_dout1"}, 32'(vram_dout1), 32'd0);
    chk({tag, "_dout2"}, 32'(vram_dout2), 32'd0);
    chk({tag, "_cdout"}, 32'(cpu_dout), 32'd0);
    chk({tag, "_cdone"}, 32'(cpu_done), 32'd0);
    chk({tag, "_mreq"}, 32'(mem_req), 32'd0);
    chk({tag, "_mwe"}, 32'(mem_we), 32'd0);
    chk({tag, "_mbe"}, 32'(mem_be), 32'd0);
    chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mdin"}, 32'(mem_din), 32'd0);
    chk({tag, "_ovr"}, 32'(overrun), 32'd0);
  endtask

  initial begin
    automatic int nv0, nd0, ncpu;
    automatic logic [AW-1:0] a, b, c, d;
    automatic bit vdone;

    repeat (3) tick();
    chk_rst("rst");
`ifdef SAM_VRAM_OVERRUN_CNT_EN
    chk("rst_cnt", 32'(overrun_cnt), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Single fetch
    mem[8] = 16'h1234;
    mem[9] = 16'h5678;
    lat = 2;
    lg.delete();
    nv0 = n_vupd;
    nd0 = n_done;
    vid(19'h00010, 19'h00012);
    tick();
    wait_idle("single_to");
    chk("single_nreq", 32'(lg.size()), 32'd2);
    chk("single_a1", 32'(lg[0].addr), 32'h8);
    chk("single_a2", 32'(lg[1].addr), 32'h9);
    chk("single_d1", 32'(vram_dout1), 32'h1234);
    chk("single_d2", 32'(vram_dout2), 32'h5678);
    chk("single_upd", 32'(n_vupd - nv0), 32'd1);
    chk("single_nodone", 32'(n_done - nd0), 32'd0);

    // Simultaneous video edge and CPU read
    mem[32'h80] = 16'hBEEF;
    lg.delete();
    nd0 = n_done;
    a = vaddr();
    b = vaddr();
    vid(a, b);
    cpu(1'b0, 19'h00101, 8'h00);
    wait_idle("prio_to");
    chk("prio_nreq", 32'(lg.size()), 32'd3);
    chk("prio_v1", 32'(lg[0].addr), 32'(a >> 1));
    chk("prio_v2", 32'(lg[1].addr), 32'(b >> 1));
    chk("prio_cpu", 32'(lg[2].addr), 32'h80);
    chk("prio_dout", 32'(cpu_dout), 32'hBE);
    chk("prio_done", 32'(n_done - nd0), 32'd1);

    // CPU write then read back
    lg.delete();
    cpu(1'b1, 19'h00003, 8'hA5);
    wait_idle("wr_to");
    chk("wr_we", 32'(lg[0].we), 32'd1);
    chk("wr_be", 32'(lg[0].be), 32'h2);
    chk("wr_din", 32'(lg[0].din), 32'hA5A5);
    chk("wr_addr", 32'(lg[0].addr), 32'h1);
    cpu(1'b0, 19'h00003, 8'h00);
    wait_idle("rb_to");
    chk("rb_dout", 32'(cpu_dout), 32'hA5);

    // Overrun: second edge lands in V1
    lat = 3;
    lg.delete();
    nv0 = n_vupd;
    a = vaddr();
    b = vaddr();
    c = vaddr();
    d = vaddr();
    vid(a, b);
    tick();
    wait_log("ovr_wait", 1);
    vid(c, d);
    tick();
    wait_idle("ovr_to");
    chk("ovr_upd", 32'(n_vupd - nv0), 32'd2);
    chk("ovr_nreq", 32'(lg.size()), 32'd4);
    chk("ovr_a2", 32'(lg[1].addr), 32'(b >> 1));
    chk("ovr_c", 32'(lg[2].addr), 32'(c >> 1));
    chk("ovr_d", 32'(lg[3].addr), 32'(d >> 1));
    chk("ovr_d1", 32'(vram_dout1), 32'(rd(int'(c >> 1))));
    chk("ovr_d2", 32'(vram_dout2), 32'(rd(int'(d >> 1))));
    chk("ovr_flag", 32'(overrun), 32'd1);
`ifdef SAM_VRAM_OVERRUN_CNT_EN
    chk("ovr_cnt", 32'(overrun_cnt), 32'd1);
    cpu_clr_cnt = 1'b1;
    tick();
    cpu_clr_cnt = 1'b0;
    chk("ovr_clr", 32'(overrun_cnt), 32'd0);
`endif

    // Reset while the second word is outstanding
    lg.delete();
    vid(vaddr(), vaddr());
    tick();
    wait_log("rm_wait", 2);
    reset = 1'b1;
    tick();
    chk_rst("rm");
    reset = 1'b0;
    vq.delete();
    nv0 = n_vupd;
    nd0 = n_done;
    wait_idle("rm_to");
    chk("rm_d1", 32'(vram_dout1), 32'd0);
    chk("rm_d2", 32'(vram_dout2), 32'd0);
    chk("rm_upd", 32'(n_vupd - nv0), 32'd0);
    chk("rm_done", 32'(n_done - nd0), 32'd0);

    // Back-to-back fetches every 16 cycles with CPU reads in between
    lat = 3;
    nv0 = n_vupd;
    nd0 = n_done;
    ncpu = 0;
    vdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          vid(vaddr(), vaddr());
          repeat (16) tick();
        end
        vdone = 1'b1;
      end
      begin
        while (!vdone) begin
          if (cq.size() == 0) begin
            repeat ($urandom_range(1, 3)) tick();
            cpu(1'b0, raddr(), 8'h00);
            ncpu++;
          end else begin
            tick();
          end
        end
      end
    join
    wait_idle("b2b_to");
    chk("b2b_ovr", 32'(overrun), 32'd0);
    chk("b2b_upd", 32'(n_vupd - nv0), 32'd20);
    chk("b2b_done", 32'(n_done - nd0), 32'(ncpu));

    // Random mix with random ack latency
    lat_rand = 1'b1;
    nd0 = n_done;
    ncpu = 0;
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        vid(vaddr(), vaddr());
      end else if (cq.size() == 0) begin
        cpu(1'b0, raddr(), 8'h00);
        ncpu++;
      end
      repeat ($urandom_range(1, 10)) tick();
    end
    wait_idle("rnd_to");
    chk("rnd_done", 32'(n_done - nd0), 32'(ncpu));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
